// File: rtl/rvx_timer_scheduler.sv
// One-shot compare channels against a free-running time base, with a
// round-robin presenter that hands expired channels to a consumer one at a time.
module rvx_timer_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int TIMER_WIDTH  = 64
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [TIMER_WIDTH-1:0]          mtime,
  input  logic                            cfg_write,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_channel,
  input  logic [TIMER_WIDTH-1:0]          cfg_compare,
  input  logic                            cfg_enable,
  output logic                            event_valid,
  output logic [$clog2(NUM_CHANNELS)-1:0] event_channel,
  input  logic                            event_ready,
  output logic [NUM_CHANNELS-1:0]         pending,
  output logic                            timer_irq
);

  localparam int CH_W = $clog2(NUM_CHANNELS);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [TIMER_WIDTH-1:0]  compare_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] armed_q;
  logic [NUM_CHANNELS-1:0] pending_q;
  logic [NUM_CHANNELS-1:0] pending_d;
  logic [NUM_CHANNELS-1:0] match;
  logic [NUM_CHANNELS-1:0] write_hit;
  logic [CH_W-1:0]         rr_ptr_q;
  logic [CH_W-1:0]         event_channel_q;
  logic [CH_W-1:0]         arb_idx;
  logic [CH_W-1:0]         arb_cand;
  logic                    arb_found;
  logic                    accept;
  logic                    load_event;
  logic                    timer_irq_q;

  always_comb begin
    match     = '0;
    write_hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      match[i]     = armed_q[i] && (mtime >= compare_q[i]);
      write_hit[i] = cfg_write && (cfg_channel == CH_W'(i));
    end
  end

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    arb_cand  = rr_ptr_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      arb_cand = rr_ptr_q + CH_W'(k);
      if (!arb_found && pending_q[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_event = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d    = PRESENT;
          load_event = 1'b1;
        end
      end
      PRESENT: begin
        if (event_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      event_channel_q <= '0;
      rr_ptr_q        <= '0;
    end else begin
      if (load_event) begin
        event_channel_q <= arb_idx;
      end
      if (accept) begin
        rr_ptr_q <= event_channel_q + CH_W'(1);
      end
    end
  end

  // A write beats a same-cycle match; a fresh expiry beats a same-cycle accept.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (accept && (event_channel_q == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (write_hit[i] && !(event_valid && (event_channel_q == CH_W'(i)))) begin
        pending_d[i] = 1'b0;
      end
      if (match[i] && !write_hit[i]) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        compare_q[i] <= '0;
      end
      armed_q     <= '0;
      pending_q   <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (write_hit[i]) begin
          compare_q[i] <= cfg_compare;
          armed_q[i]   <= cfg_enable;
        end else if (match[i]) begin
          armed_q[i] <= 1'b0;
        end
      end
      pending_q   <= pending_d;
      timer_irq_q <= |pending_q;
    end
  end

  assign event_valid   = (state_q == PRESENT);
  assign event_channel = event_channel_q;
  assign pending       = pending_q;
  assign timer_irq     = timer_irq_q;

endmodule

// File: tb/tb_rvx_timer_scheduler.sv
// Directed, self-checking bench for rvx_timer_scheduler (4 channels, 64-bit time).
module tb_rvx_timer_scheduler;

  localparam logic [63:0] MAX_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] mtime;
  logic        cfg_write;
  logic [1:0]  cfg_channel;
  logic [63:0] cfg_compare;
  logic        cfg_enable;
  logic        event_valid;
  logic [1:0]  event_channel;
  logic        event_ready;
  logic [3:0]  pending;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;
  int got[4];
  int got_count;
  logic seen_activity;

  rvx_timer_scheduler #(
    .NUM_CHANNELS(4),
    .TIMER_WIDTH (64)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mtime        (mtime),
    .cfg_write    (cfg_write),
    .cfg_channel  (cfg_channel),
    .cfg_compare  (cfg_compare),
    .cfg_enable   (cfg_enable),
    .event_valid  (event_valid),
    .event_channel(event_channel),
    .event_ready  (event_ready),
    .pending      (pending),
    .timer_irq    (timer_irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [63:0] cmp, input logic en);
    cfg_write   = 1'b1;
    cfg_channel = ch;
    cfg_compare = cmp;
    cfg_enable  = en;
    tick();
    cfg_write   = 1'b0;
  endtask

  task automatic doReset(input string tag);
    reset_n     = 1'b0;
    cfg_write   = 1'b0;
    cfg_channel = '0;
    cfg_compare = '0;
    cfg_enable  = 1'b0;
    event_ready = 1'b0;
    mtime       = '0;
    tick();
    tick();
    checkOutput(tag, {event_valid, event_channel, pending, timer_irq}, 64'd0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic waitEvent(input string tag, input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (event_valid) break;
      tick();
    end
    checkOutput(tag, event_valid, 64'd1);
  endtask

  // Records the channel of every presentation seen while event_ready is high.
  task automatic collectEvents(input int cycles);
    got_count = 0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (event_valid && event_ready && got_count < 4) begin
        got[got_count] = int'(event_channel);
        got_count++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog bench did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting");

    // Basic expiry timing on channel 1.
    doReset("t1_reset");
    mtime = 64'd90;
    applyStimulus(2'd1, 64'd100, 1'b1);
    for (int m = 95; m <= 105; m++) begin
      mtime = 64'(m);
      if (m == 100) checkOutput("t1_pending_m100", pending, 64'd0);
      if (m == 101) begin
        checkOutput("t1_pending_m101", pending, 64'b0010);
        checkOutput("t1_valid_m101", event_valid, 64'd0);
        checkOutput("t1_irq_m101", timer_irq, 64'd0);
      end
      if (m == 102) begin
        checkOutput("t1_valid_m102", event_valid, 64'd1);
        checkOutput("t1_chan_m102", event_channel, 64'd1);
        checkOutput("t1_irq_m102", timer_irq, 64'd1);
      end
      if (m == 105) checkOutput("t1_valid_held", event_valid, 64'd1);
      tick();
    end
    event_ready = 1'b1;
    tick();
    checkOutput("t1_accept_valid", event_valid, 64'd0);
    checkOutput("t1_accept_pending", pending, 64'd0);
    checkOutput("t1_irq_lag", timer_irq, 64'd1);
    event_ready = 1'b0;
    tick();
    checkOutput("t1_irq_clear", timer_irq, 64'd0);

    // Round-robin ordering; ready held high, including while idle.
    doReset("t2_reset");
    mtime = 64'd10;
    event_ready = 1'b1;
    applyStimulus(2'd0, 64'd50, 1'b1);
    applyStimulus(2'd2, 64'd50, 1'b1);
    applyStimulus(2'd3, 64'd50, 1'b1);
    checkOutput("t2_idle_quiet", {event_valid, pending}, 64'd0);
    mtime = 64'd60;
    collectEvents(20);
    checkOutput("t2_count", got_count, 64'd3);
    checkOutput("t2_first", got[0], 64'd0);
    checkOutput("t2_second", got[1], 64'd2);
    checkOutput("t2_third", got[2], 64'd3);
    checkOutput("t2_drained", pending, 64'd0);
    mtime = 64'd10;
    applyStimulus(2'd3, 64'd50, 1'b1);
    applyStimulus(2'd0, 64'd50, 1'b1);
    mtime = 64'd60;
    collectEvents(20);
    checkOutput("t2_rearm_count", got_count, 64'd2);
    checkOutput("t2_rearm_first", got[0], 64'd0);
    checkOutput("t2_rearm_second", got[1], 64'd3);
    event_ready = 1'b0;

    // Presented channel holds under backpressure; writes clear only other channels.
    doReset("t3_reset");
    mtime = 64'd60;
    applyStimulus(2'd2, 64'd70, 1'b1);
    applyStimulus(2'd3, 64'd70, 1'b1);
    mtime = 64'd80;
    waitEvent("t3_present", 10);
    checkOutput("t3_chan", event_channel, 64'd2);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) applyStimulus(2'd2, 64'd1000, 1'b1);
      else if (c == 6) applyStimulus(2'd3, 64'd1000, 1'b1);
      else tick();
      checkOutput("t3_hold", {event_valid, event_channel, pending},
                  (c >= 6) ? {57'd0, 1'b1, 2'd2, 4'b0100} : {57'd0, 1'b1, 2'd2, 4'b1100});
    end
    event_ready = 1'b1;
    tick();
    checkOutput("t3_accept", {event_valid, pending}, 64'd0);
    event_ready = 1'b0;

    // Write and match collide: write wins, new compare then matches.
    doReset("t4_reset");
    mtime = 64'd100;
    applyStimulus(2'd1, 64'd150, 1'b1);
    mtime = 64'd200;
    applyStimulus(2'd1, 64'd200, 1'b1);
    mtime = 64'd201;
    checkOutput("t4_write_wins", pending, 64'd0);
    tick();
    mtime = 64'd202;
    checkOutput("t4_fire_201", pending, 64'b0010);
    tick();
    checkOutput("t4_present", {event_valid, event_channel}, {61'd0, 1'b1, 2'd1});

    // Reset asserted while presenting.
    doReset("t5_reset");
    applyStimulus(2'd3, 64'd5, 1'b1);
    mtime = 64'd10;
    waitEvent("t5_present", 10);
    checkOutput("t5_pre_state", {event_channel, pending, timer_irq}, {57'd0, 2'd3, 4'b1000, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_in_reset", {event_valid, event_channel, pending, timer_irq}, 64'd0);
    tick();
    tick();
    checkOutput("t5_still_reset", {event_valid, pending, timer_irq}, 64'd0);
    reset_n = 1'b1;
    mtime = 64'd1000;
    seen_activity = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen_activity = seen_activity | event_valid | (|pending) | timer_irq;
    end
    checkOutput("t5_no_fire", seen_activity, 64'd0);

    // Extremes of the unsigned compare.
    doReset("t6_reset");
    mtime = MAX_TIME;
    applyStimulus(2'd0, 64'd0, 1'b1);
    checkOutput("t6_zero_write", pending, 64'd0);
    tick();
    checkOutput("t6_zero_match", pending, 64'b0001);
    doReset("t6_reset_b");
    mtime = MAX_TIME - 64'd1;
    applyStimulus(2'd1, MAX_TIME, 1'b1);
    tick();
    checkOutput("t6_max_nomatch", pending, 64'd0);
    mtime = MAX_TIME;
    tick();
    checkOutput("t6_max_match", pending, 64'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
